// File: rtl/deser_pkg.sv
// Shared definitions for the deserializer/serializer pair.
//   deser_state_t : controller state (FILL accumulating, FULL word parked)
//   cnt_w()       : beat-counter width for a given beats-per-word count
//   beat_lsb()    : bit offset of beat idx inside a packed word of dw-bit beats
package deser_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } deser_state_t;

    // Clamp to 1 so a degenerate count still yields a legal vector width.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int beat_lsb(input int idx, input int dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/deser_beat_counter.sv
// Beat counter for the deserializer accumulator.
//   clk, rst : clock, synchronous active-high clear
//   inc      : advance by one (normal beat accepted)
//   sof      : reload to 1 (start-of-frame beat lands at index 0)
//   wrap     : return to 0 (word handed to the output register)
//   cnt      : beats currently held
//   is_last  : cnt == SHIFT_NUM-1, the next beat completes the word
//   is_zero  : cnt == 0, no partial word pending
module deser_beat_counter
    import deser_pkg::*;
#(
    parameter int SHIFT_NUM = 16,
    parameter int CNT_W     = cnt_w(SHIFT_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             sof,
    input  logic             wrap,
    output logic [CNT_W-1:0] cnt,
    output logic             is_last,
    output logic             is_zero
);

    // wrap beats sof beats inc; the controller never raises two at once,
    // but a fixed priority keeps the register well defined regardless.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (wrap)
            cnt <= '0;
        else if (sof)
            cnt <= CNT_W'(1);
        else if (inc)
            cnt <= cnt + CNT_W'(1);
    end

    assign is_last = (cnt == CNT_W'(SHIFT_NUM - 1));
    assign is_zero = (cnt == '0);

endmodule

// File: rtl/para_deser_ctrl.sv
// Parallel deserializer controller: packs SHIFT_NUM narrow beats into one
// wide word with valid/ready on both sides and start-of-frame realignment.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_valid/o_ready/i_data: upstream beat handshake (accept = i_valid & o_ready)
//   i_sof                 : accepted beat starts a new word
//   o_valid/i_ready/o_data: downstream word handshake, beat k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_beat_cnt            : beats held for the word in progress
//   o_align_err           : one-cycle pulse when i_sof discards a partial word
module para_deser_ctrl
    import deser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SHIFT_NUM  = 16,
    parameter int CNT_W      = cnt_w(SHIFT_NUM)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [DATA_WIDTH-1:0]           i_data,
    input  logic                            i_sof,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [DATA_WIDTH*SHIFT_NUM-1:0] o_data,
    output logic [CNT_W-1:0]                o_beat_cnt,
    output logic                            o_align_err
);

    localparam int WORD_W = DATA_WIDTH * SHIFT_NUM;

    deser_state_t state, state_nxt;

    logic [SHIFT_NUM-1:0][DATA_WIDTH-1:0] acc;
    logic [WORD_W-1:0]                    word_nxt;
    logic [CNT_W-1:0]                     cnt;
    logic [CNT_W-1:0]                     wr_idx;
    logic                                 cnt_last, cnt_zero;
    logic                                 accept, out_free;
    logic                                 acc_we, load_out, last_direct;
    logic                                 cnt_inc, cnt_sof, cnt_wrap, realign;

    assign o_ready    = (state == ST_FILL);
    assign accept     = i_valid & o_ready;
    assign out_free   = ~o_valid | i_ready;
    assign o_beat_cnt = cnt;

    deser_beat_counter #(
        .SHIFT_NUM (SHIFT_NUM),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk     (i_clk),
        .rst     (i_rst),
        .inc     (cnt_inc),
        .sof     (cnt_sof),
        .wrap    (cnt_wrap),
        .cnt     (cnt),
        .is_last (cnt_last),
        .is_zero (cnt_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= ST_FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        acc_we      = 1'b0;
        load_out    = 1'b0;
        last_direct = 1'b0;
        cnt_inc     = 1'b0;
        cnt_sof     = 1'b0;
        cnt_wrap    = 1'b0;
        realign     = 1'b0;
        unique case (state)
            ST_FILL: begin
                if (accept) begin
                    acc_we = 1'b1;
                    if (i_sof) begin
                        // Realignment wins even on the would-be last beat.
                        cnt_sof = 1'b1;
                        realign = ~cnt_zero;
                    end else if (cnt_last) begin
                        if (out_free) begin
                            // Last beat bypasses the accumulator straight into the word.
                            load_out    = 1'b1;
                            last_direct = 1'b1;
                            cnt_wrap    = 1'b1;
                        end else begin
                            state_nxt = ST_FULL;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (out_free) begin
                    load_out  = 1'b1;
                    cnt_wrap  = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    assign wr_idx = i_sof ? '0 : cnt;

    always_comb begin
        word_nxt = '0;
        for (int k = 0; k < SHIFT_NUM; k++)
            word_nxt[beat_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = acc[k];
        if (last_direct)
            word_nxt[beat_lsb(SHIFT_NUM - 1, DATA_WIDTH) +: DATA_WIDTH] = i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc         <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_align_err <= 1'b0;
        end else begin
            if (acc_we)
                acc[wr_idx] <= i_data;
            // o_data only changes on load, and load needs out_free, so a
            // stalled word is never overwritten.
            if (load_out) begin
                o_data  <= word_nxt;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            o_align_err <= realign;
        end
    end

endmodule

// File: tb/tb_para_deser_ctrl.sv
module tb_para_deser_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_data;
    logic        i_sof;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [1:0]  o_beat_cnt;
    logic        o_align_err;

    int tests = 0;
    int fails = 0;

    para_deser_ctrl #(.DATA_WIDTH(8), .SHIFT_NUM(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .i_sof       (i_sof),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_beat_cnt  (o_beat_cnt),
        .o_align_err (o_align_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        sof;
        logic        rdy;
        logic        ev;
        logic        erdy;
        logic [31:0] edata;
        logic [1:0]  ecnt;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic sof, input logic rdy,
                       input logic ev, input logic erdy, input logic [31:0] edata,
                       input logic [1:0] ecnt, input logic eerr);
        vec_t t;
        t.v = v; t.d = d; t.sof = sof; t.rdy = rdy;
        t.ev = ev; t.erdy = erdy; t.edata = edata; t.ecnt = ecnt; t.eerr = eerr;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic rst, input logic v, input logic [7:0] d,
                         input logic sof, input logic rdy);
        @(negedge i_clk);
        i_rst = rst; i_valid = v; i_data = d; i_sof = sof; i_ready = rdy;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] part, held, w;
        logic        hold_chk;
        int          pc, sent, cyc;

        i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_sof = 1'b0; i_ready = 1'b0;

        // v  d    sof rdy | ev erdy edata         cnt err
        // four beats, sof on the first (cnt==0: no error)
        add(1, 8'h01, 1, 1,   0, 1, 32'h0,        1, 0);
        add(1, 8'h02, 0, 1,   0, 1, 32'h0,        2, 0);
        add(1, 8'h03, 0, 1,   0, 1, 32'h0,        3, 0);
        add(1, 8'h04, 0, 1,   1, 1, 32'h04030201, 0, 0);
        add(0, 8'h00, 0, 1,   0, 1, 32'h0,        0, 0);
        // continuous stream, no ready drop
        add(1, 8'h00, 0, 1,   0, 1, 32'h0,        1, 0);
        add(1, 8'h01, 0, 1,   0, 1, 32'h0,        2, 0);
        add(1, 8'h02, 0, 1,   0, 1, 32'h0,        3, 0);
        add(1, 8'h03, 0, 1,   1, 1, 32'h03020100, 0, 0);
        add(1, 8'h04, 0, 1,   0, 1, 32'h0,        1, 0);
        add(1, 8'h05, 0, 1,   0, 1, 32'h0,        2, 0);
        add(1, 8'h06, 0, 1,   0, 1, 32'h0,        3, 0);
        add(1, 8'h07, 0, 1,   1, 1, 32'h07060504, 0, 0);
        add(0, 8'h00, 0, 1,   0, 1, 32'h0,        0, 0);
        // mid-word realignment
        add(1, 8'hAA, 0, 1,   0, 1, 32'h0,        1, 0);
        add(1, 8'hBB, 0, 1,   0, 1, 32'h0,        2, 0);
        add(1, 8'hBC, 1, 1,   0, 1, 32'h0,        1, 1);
        add(1, 8'h11, 0, 1,   0, 1, 32'h0,        2, 0);
        add(1, 8'h22, 0, 1,   0, 1, 32'h0,        3, 0);
        add(1, 8'h33, 0, 1,   1, 1, 32'h332211BC, 0, 0);
        add(0, 8'h00, 0, 1,   0, 1, 32'h0,        0, 0);
        // sof on the would-be last beat realigns instead of completing
        add(1, 8'h10, 0, 1,   0, 1, 32'h0,        1, 0);
        add(1, 8'h20, 0, 1,   0, 1, 32'h0,        2, 0);
        add(1, 8'h30, 0, 1,   0, 1, 32'h0,        3, 0);
        add(1, 8'h40, 1, 1,   0, 1, 32'h0,        1, 1);
        add(1, 8'h50, 0, 1,   0, 1, 32'h0,        2, 0);
        add(1, 8'h60, 0, 1,   0, 1, 32'h0,        3, 0);
        add(1, 8'h70, 0, 1,   1, 1, 32'h70605040, 0, 0);
        add(0, 8'h00, 0, 1,   0, 1, 32'h0,        0, 0);
        // downstream stalled across two words: first held, second parks (FULL)
        add(1, 8'h00, 0, 0,   0, 1, 32'h0,        1, 0);
        add(1, 8'h01, 0, 0,   0, 1, 32'h0,        2, 0);
        add(1, 8'h02, 0, 0,   0, 1, 32'h0,        3, 0);
        add(1, 8'h03, 0, 0,   1, 1, 32'h03020100, 0, 0);
        add(1, 8'h04, 0, 0,   1, 1, 32'h03020100, 1, 0);
        add(1, 8'h05, 0, 0,   1, 1, 32'h03020100, 2, 0);
        add(1, 8'h06, 0, 0,   1, 1, 32'h03020100, 3, 0);
        add(1, 8'h07, 0, 0,   1, 0, 32'h03020100, 3, 0);
        add(1, 8'hFF, 1, 0,   1, 0, 32'h03020100, 3, 0);  // not accepted: sof ignored
        add(0, 8'h00, 0, 1,   1, 1, 32'h07060504, 0, 0);
        add(0, 8'h00, 0, 1,   0, 1, 32'h0,        0, 0);

        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        chk("rst_valid", 32'(o_valid),     32'h0);
        chk("rst_ready", 32'(o_ready),     32'h1);
        chk("rst_data",  o_data,           32'h0);
        chk("rst_cnt",   32'(o_beat_cnt),  32'h0);
        chk("rst_err",   32'(o_align_err), 32'h0);

        foreach (tbl[i]) begin
            drive(1'b0, tbl[i].v, tbl[i].d, tbl[i].sof, tbl[i].rdy);
            chk($sformatf("v%0d_valid", i), 32'(o_valid),     32'(tbl[i].ev));
            chk($sformatf("v%0d_ready", i), 32'(o_ready),     32'(tbl[i].erdy));
            chk($sformatf("v%0d_cnt", i),   32'(o_beat_cnt),  32'(tbl[i].ecnt));
            chk($sformatf("v%0d_err", i),   32'(o_align_err), 32'(tbl[i].eerr));
            if (tbl[i].ev)
                chk($sformatf("v%0d_data", i), o_data, tbl[i].edata);
        end

        // reset mid-word with a stalled word in the output register
        drive(0, 1, 8'h01, 0, 0);
        drive(0, 1, 8'h02, 0, 0);
        drive(0, 1, 8'h03, 0, 0);
        drive(0, 1, 8'h04, 0, 0);
        drive(0, 1, 8'h05, 0, 0);
        drive(0, 1, 8'h06, 0, 0);
        chk("prerst_valid", 32'(o_valid),    32'h1);
        chk("prerst_cnt",   32'(o_beat_cnt), 32'h2);
        drive(1, 1, 8'h07, 1, 1);
        chk("mrst_valid", 32'(o_valid),     32'h0);
        chk("mrst_cnt",   32'(o_beat_cnt),  32'h0);
        chk("mrst_ready", 32'(o_ready),     32'h1);
        chk("mrst_data",  o_data,           32'h0);
        chk("mrst_err",   32'(o_align_err), 32'h0);
        drive(0, 1, 8'hA1, 0, 1);
        drive(0, 1, 8'hA2, 0, 1);
        drive(0, 1, 8'hA3, 0, 1);
        drive(0, 1, 8'hA4, 0, 1);
        chk("postrst_valid", 32'(o_valid), 32'h1);
        chk("postrst_data",  o_data,       32'hA4A3A2A1);
        drive(0, 0, 8'h00, 0, 1);
        chk("postrst_drain", 32'(o_valid), 32'h0);

        // random valid/ready stalls against a beat-packing scoreboard
        part = '0; pc = 0; sent = 0; cyc = 0; hold_chk = 1'b0; held = '0;
        while ((sent < 10000 || exp_q.size() > 0 || o_valid) && cyc < 60000) begin
            @(negedge i_clk);
            i_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
            i_data  = 8'($urandom);
            i_sof   = 1'b0;
            i_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (hold_chk) begin
                chk("rnd_hold_valid", 32'(o_valid), 32'h1);
                chk("rnd_hold_data",  o_data,       held);
            end
            if (i_valid && o_ready) begin
                part[pc*8 +: 8] = i_data;
                pc++;
                sent++;
                if (pc == 4) begin
                    exp_q.push_back(part);
                    pc = 0;
                end
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_extra_word", o_data, 32'hxxxxxxxx);
                end else begin
                    w = exp_q.pop_front();
                    chk("rnd_word", o_data, w);
                end
            end
            hold_chk = o_valid && !i_ready;
            held     = o_data;
            cyc++;
            @(posedge i_clk);
        end
        chk("rnd_timeout",   32'(cyc < 60000),      32'h1);
        chk("rnd_leftover",  32'(exp_q.size()),     32'h0);
        chk("rnd_beats_all", 32'(sent),             32'd10000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
